fifo_packetizer: RTL and testbench
==================================

FIFO_PACKETIZER -- requirements
Module: fifo_packetizer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the FIFO word width and the output beat width.
REQ-002 The block SHALL have parameter PKT_LEN, default 4, giving payload words per packet; legal range 1..255.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the packet counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pop_valid_i  input  1  upstream FIFO holds a word.
REQ-007 pop_data_i  input  DATA_WIDTH  upstream FIFO head word, valid when pop_valid_i=1.
REQ-008 pop_grant_o  output  1  consumes the head word when pop_valid_i=1 in the same cycle.
REQ-009 out_data_o  output  DATA_WIDTH  packet beat.
REQ-010 out_valid_o  output  1  out_data_o, out_sop_o and out_eop_o are valid.
REQ-011 out_ready_i  input  1  downstream accepts a beat when out_valid_o=1.
REQ-012 out_sop_o  output  1  current beat is the header.
REQ-013 out_eop_o  output  1  current beat is the trailer.
REQ-014 pkt_cnt_o  output  CNT_WIDTH  count of completed packets, wraps modulo 2^CNT_WIDTH.

Function
REQ-015 Input transfer SHALL occur in a cycle with pop_valid_i=1 and pop_grant_o=1; output transfer SHALL occur in a cycle with out_valid_o=1 and out_ready_i=1.
REQ-016 Outputs SHALL come from a single registered output slot; slot_free = !out_valid_o || out_ready_i.
REQ-017 States: IDLE, PAYLOAD, TRAILER.
REQ-018 IDLE: when pop_valid_i=1 and slot_free, the block SHALL load the slot with data=seq, sop=1, eop=0, valid=1, then clear the word count and XOR accumulator and go to PAYLOAD; no word is popped.
REQ-019 PAYLOAD: pop_grant_o SHALL equal slot_free, combinationally, and SHALL be 0 in every other state.
REQ-020 In PAYLOAD, on each input transfer the block SHALL load the slot with data=pop_data_i, sop=0, eop=0, valid=1, XOR the word into the accumulator, and increment the word count.
REQ-021 On the PKT_LEN-th input transfer the block SHALL go to TRAILER.
REQ-022 TRAILER: when slot_free, the block SHALL load the slot with data=accumulator (XOR of all payload words), sop=0, eop=1, valid=1.
REQ-023 In the same TRAILER load cycle, seq SHALL increment (DATA_WIDTH bits, wraps), pkt_cnt_o SHALL increment, and the FSM SHALL go to IDLE.
REQ-024 If no new beat is loaded and out_ready_i=1, out_valid_o SHALL clear the next cycle.
REQ-025 While out_valid_o=1 and out_ready_i=0, out_data_o, out_sop_o and out_eop_o SHALL hold stable.
REQ-026 Loading a new beat in the same cycle that the old beat transfers SHALL give full throughput: one beat per cycle.
REQ-027 A packet SHALL be exactly PKT_LEN+2 beats.
REQ-028 When the FIFO is empty mid-packet, the block SHALL wait in PAYLOAD indefinitely with no timeout; any already-loaded beat still drains normally.
REQ-029 Counters SHALL wrap silently: seq from 2^DATA_WIDTH-1 to 0, pkt_cnt_o from max to 0.
REQ-030 Word count width SHALL be sized for PKT_LEN; the PKT_LEN=1 case SHALL go PAYLOAD->TRAILER after one word.

Reset
REQ-031 While rst=1, regardless of clk: state=IDLE, out_valid_o=0, out_sop_o=0, out_eop_o=0, out_data_o=0, seq=0, accumulator=0, word count=0, pkt_cnt_o=0.
REQ-032 pop_grant_o SHALL be 0 whenever state=IDLE, including during reset.
REQ-033 Reset asserted mid-packet SHALL abandon the partial packet with no trailer emitted; words already popped are lost.
REQ-034 After reset deassertion the next packet header SHALL be 0x00.

Verification (DATA_WIDTH=8, PKT_LEN=4)
REQ-035 FIFO holds 0x11,0x22,0x33,0x44, out_ready_i=1 -> beats 0x00(sop),0x11,0x22,0x33,0x44,0x44(eop) on consecutive cycles; pkt_cnt_o=1.
REQ-036 Second packet 0x01,0x02,0x03,0x04 -> header 0x01, trailer 0x04, pkt_cnt_o=2.
REQ-037 out_ready_i=0 for 5 cycles while beat 0x22 is presented -> 0x22 held, pop_grant_o=0, no word popped; sequence resumes intact.
REQ-038 FIFO empties after 0x11,0x22 -> no further beats, state stays PAYLOAD; pushing 0x33,0x44 completes packet with trailer 0x44.
REQ-039 rst pulsed after 2 payload beats -> outputs zero immediately; next packet header 0x00, pkt_cnt_o=0.
REQ-040 256 packets of zeros -> packet 257 header 0x00, all trailers 0x00, pkt_cnt_o=257.

Source files
------------

// File: rtl/fifo_packetizer_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fifo_packetizer_if : FIFO pop side and packet output side of fifo_packetizer
// Revision 1.0
// -----------------------------------------------------------------------------
interface fifo_packetizer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pop_valid_i;
  logic [DATA_WIDTH-1:0] pop_data_i;
  logic                  pop_grant_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic                  out_sop_o;
  logic                  out_eop_o;

  modport master (
    output pop_valid_i, pop_data_i, out_ready_i,
    input  pop_grant_o, out_data_o, out_valid_o, out_sop_o, out_eop_o
  );

  modport slave (
    input  pop_valid_i, pop_data_i, out_ready_i,
    output pop_grant_o, out_data_o, out_valid_o, out_sop_o, out_eop_o
  );
endinterface
`default_nettype wire

// File: rtl/fifo_packetizer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fifo_packetizer : frames FIFO words as header(seq) + PKT_LEN payload + XOR trailer
// Revision 1.0
// -----------------------------------------------------------------------------
module fifo_packetizer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  fifo_packetizer_if.slave          bus,
  output logic [CNT_WIDTH-1:0]      pkt_cnt_o
);

  localparam int                  WCNT_W    = $clog2(PKT_LEN + 1);
  localparam logic [WCNT_W-1:0]   LAST_WORD = WCNT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } state_t;

  state_t                state_q,     state_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sop_q,   out_sop_d;
  logic                  out_eop_q,   out_eop_d;
  logic [DATA_WIDTH-1:0] seq_q,       seq_d;
  logic [DATA_WIDTH-1:0] acc_q,       acc_d;
  logic [WCNT_W-1:0]     wcnt_q,      wcnt_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q,   pkt_cnt_d;
  logic                  slot_free;
  logic                  grant;

  assign slot_free = !out_valid_q || bus.out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      seq_q       <= '0;
      acc_q       <= '0;
      wcnt_q      <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      seq_q       <= seq_d;
      acc_q       <= acc_d;
      wcnt_q      <= wcnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    // a beat that is accepted and not replaced leaves the slot empty
    out_valid_d = out_valid_q && !bus.out_ready_i;
    seq_d       = seq_q;
    acc_d       = acc_q;
    wcnt_d      = wcnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    grant       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.pop_valid_i && slot_free) begin
          out_data_d  = seq_q;
          out_sop_d   = 1'b1;
          out_eop_d   = 1'b0;
          out_valid_d = 1'b1;
          wcnt_d      = '0;
          acc_d       = '0;
          state_d     = PAYLOAD;
        end
      end
      PAYLOAD: begin
        grant = slot_free;
        if (bus.pop_valid_i && slot_free) begin
          out_data_d  = bus.pop_data_i;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          out_valid_d = 1'b1;
          acc_d       = acc_q ^ bus.pop_data_i;
          wcnt_d      = wcnt_q + 1'b1;
          if (wcnt_q == LAST_WORD) begin
            state_d = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (slot_free) begin
          out_data_d  = acc_q;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b1;
          out_valid_d = 1'b1;
          seq_d       = seq_q + 1'b1;
          pkt_cnt_d   = pkt_cnt_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.pop_grant_o = grant;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_sop_o   = out_sop_q;
  assign bus.out_eop_o   = out_eop_q;
  assign pkt_cnt_o       = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_packetizer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fifo_packetizer : directed self-checking bench for fifo_packetizer (8-bit, 4 words)
// Revision 1.0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_packetizer;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
    int         cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pkt_cnt;
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  beat_t       cap[$];
  beat_t       mon_b;
  logic [7:0]  fifo_q[$];

  fifo_packetizer_if #(.DATA_WIDTH(8)) bus ();

  fifo_packetizer #(
    .DATA_WIDTH (8),
    .PKT_LEN    (4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pkt_cnt_o (pkt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Record output transfers and FIFO pops half a cycle before the edge that commits them
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      mon_b.sop  = bus.out_sop_o;
      mon_b.eop  = bus.out_eop_o;
      mon_b.data = bus.out_data_o;
      mon_b.cyc  = cycle;
      cap.push_back(mon_b);
    end
    if (!rst && bus.pop_valid_i && bus.pop_grant_o && fifo_q.size() != 0)
      void'(fifo_q.pop_front());
  end

  always @(posedge clk) begin
    #2;
    bus.pop_valid_i = (fifo_q.size() != 0);
    bus.pop_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (cap.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.out_ready_i = 1'b1;
    fifo_q.delete();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.out_valid_o); end
    checks++; if (bus.out_sop_o !== 1'b0) begin errors++; $display("FAIL rst_sop got %b want 0", bus.out_sop_o); end
    checks++; if (bus.out_eop_o !== 1'b0) begin errors++; $display("FAIL rst_eop got %b want 0", bus.out_eop_o); end
    checks++; if (bus.out_data_o !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", bus.out_data_o); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_pkt_cnt got %0d want 0", pkt_cnt); end
    checks++; if (bus.pop_grant_o !== 1'b0) begin errors++; $display("FAIL rst_grant got %b want 0", bus.pop_grant_o); end
    rst = 1'b0;
    cap.delete();
  endtask

  task automatic test_basic;
    logic [7:0] exp_d [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    bit ok;
    cap.delete();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    wait_beats(6, 40, ok);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got %0d beats want 6", cap.size()); end
    checks++; if (cap.size() != 6) begin errors++; $display("FAIL basic_len got %0d beats want 6", cap.size()); end
    if (cap.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (cap[i].data !== exp_d[i]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, cap[i].data, exp_d[i]); end
        checks++; if (cap[i].sop !== (i == 0)) begin errors++; $display("FAIL basic_sop[%0d] got %b want %b", i, cap[i].sop, (i == 0)); end
        checks++; if (cap[i].eop !== (i == 5)) begin errors++; $display("FAIL basic_eop[%0d] got %b want %b", i, cap[i].eop, (i == 5)); end
      end
      checks++; if (cap[5].cyc - cap[0].cyc != 5) begin errors++; $display("FAIL basic_throughput got %0d cycles want 5", cap[5].cyc - cap[0].cyc); end
    end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL basic_pkt_cnt got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_second;
    logic [7:0] exp_d [6] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    bit ok;
    cap.delete();
    fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    wait_beats(6, 40, ok);
    #0;
    checks++; if (!ok) begin errors++; $display("FAIL second_timeout got %0d beats want 6", cap.size()); end
    if (cap.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (cap[i].data !== exp_d[i]) begin errors++; $display("FAIL second_data[%0d] got %h want %h", i, cap[i].data, exp_d[i]); end
      end
      checks++; if (cap[0].sop !== 1'b1 || cap[5].eop !== 1'b1) begin errors++; $display("FAIL second_flags got sop=%b eop=%b want 1 1", cap[0].sop, cap[5].eop); end
    end
    checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL second_pkt_cnt got %0d want 2", pkt_cnt); end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_d [6] = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    bit ok;
    bit found = 1'b0;
    cap.delete();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid_o && bus.out_data_o == 8'h22) begin
        found = 1'b1;
        break;
      end
    end
    bus.out_ready_i = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL bp_find got no 22 beat want 22 presented"); end
    repeat (5) begin
      @(posedge clk); #1;
      checks++; if (bus.out_data_o !== 8'h22 || bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold got data=%h valid=%b want 22 1", bus.out_data_o, bus.out_valid_o); end
      checks++; if (bus.pop_grant_o !== 1'b0) begin errors++; $display("FAIL bp_grant got %b want 0", bus.pop_grant_o); end
    end
    checks++; if (fifo_q.size() != 2) begin errors++; $display("FAIL bp_fifo_level got %0d want 2", fifo_q.size()); end
    bus.out_ready_i = 1'b1;
    wait_beats(6, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got %0d beats want 6", cap.size()); end
    if (cap.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (cap[i].data !== exp_d[i] || cap[i].sop !== (i == 0) || cap[i].eop !== (i == 5)) begin
          errors++; $display("FAIL bp_beat[%0d] got %h/%b/%b want %h/%b/%b", i, cap[i].data, cap[i].sop, cap[i].eop, exp_d[i], (i == 0), (i == 5));
        end
      end
    end
    checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL bp_pkt_cnt got %0d want 3", pkt_cnt); end
  endtask

  task automatic test_underflow;
    bit ok;
    cap.delete();
    fifo_q = '{8'h11, 8'h22};
    repeat (12) @(posedge clk);
    #1;
    checks++; if (cap.size() != 3) begin errors++; $display("FAIL uf_beats got %0d want 3", cap.size()); end
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL uf_valid got %b want 0", bus.out_valid_o); end
    checks++; if (dut.state_q !== 2'd1) begin errors++; $display("FAIL uf_state got %0d want 1", dut.state_q); end
    checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL uf_pkt_cnt got %0d want 3", pkt_cnt); end
    fifo_q.push_back(8'h33);
    fifo_q.push_back(8'h44);
    wait_beats(6, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL uf_timeout got %0d beats want 6", cap.size()); end
    if (cap.size() >= 6) begin
      checks++; if (cap[0].data !== 8'h03 || cap[0].sop !== 1'b1) begin errors++; $display("FAIL uf_header got %h/%b want 03/1", cap[0].data, cap[0].sop); end
      checks++; if (cap[5].data !== 8'h44 || cap[5].eop !== 1'b1) begin errors++; $display("FAIL uf_trailer got %h/%b want 44/1", cap[5].data, cap[5].eop); end
    end
    checks++; if (pkt_cnt !== 16'd4) begin errors++; $display("FAIL uf_pkt_cnt_end got %0d want 4", pkt_cnt); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    cap.delete();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    wait_beats(3, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_timeout got %0d beats want 3", cap.size()); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0 || bus.out_sop_o !== 1'b0 || bus.out_eop_o !== 1'b0) begin
      errors++; $display("FAIL rm_flags got v=%b s=%b e=%b want 0 0 0", bus.out_valid_o, bus.out_sop_o, bus.out_eop_o);
    end
    checks++; if (bus.out_data_o !== 8'h00) begin errors++; $display("FAIL rm_data got %h want 00", bus.out_data_o); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rm_pkt_cnt got %0d want 0", pkt_cnt); end
    checks++; if (bus.pop_grant_o !== 1'b0 || dut.state_q !== 2'd0) begin errors++; $display("FAIL rm_idle got grant=%b state=%0d want 0 0", bus.pop_grant_o, dut.state_q); end
    fifo_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cap.delete();
    fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    wait_beats(6, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_post_timeout got %0d beats want 6", cap.size()); end
    if (cap.size() >= 6) begin
      checks++; if (cap[0].data !== 8'h00 || cap[0].sop !== 1'b1) begin errors++; $display("FAIL rm_header got %h/%b want 00/1", cap[0].data, cap[0].sop); end
      checks++; if (cap[5].data !== 8'h04 || cap[5].eop !== 1'b1) begin errors++; $display("FAIL rm_trailer got %h/%b want 04/1", cap[5].data, cap[5].eop); end
    end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL rm_pkt_cnt_end got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_wrap;
    bit ok;
    @(posedge clk); #1;
    rst = 1'b1;
    fifo_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cap.delete();
    for (int i = 0; i < 257 * 4; i++) fifo_q.push_back(8'h00);
    wait_beats(257 * 6, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got %0d beats want %0d", cap.size(), 257 * 6); end
    if (cap.size() >= 257 * 6) begin
      for (int p = 0; p < 257; p++) begin
        checks++; if (cap[p*6].data !== 8'(p) || cap[p*6].sop !== 1'b1) begin
          errors++; $display("FAIL wrap_header[%0d] got %h/%b want %h/1", p, cap[p*6].data, cap[p*6].sop, 8'(p));
        end
        checks++; if (cap[p*6+5].data !== 8'h00 || cap[p*6+5].eop !== 1'b1) begin
          errors++; $display("FAIL wrap_trailer[%0d] got %h/%b want 00/1", p, cap[p*6+5].data, cap[p*6+5].eop);
        end
      end
    end
    checks++; if (pkt_cnt !== 16'd257) begin errors++; $display("FAIL wrap_pkt_cnt got %0d want 257", pkt_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_second();
    test_backpressure();
    test_underflow();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
